// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // FETCH: request at pc; DRAIN: waiting out a stale request; FULL: buffer parked
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        FULL  = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry holding buffer for an instruction that returned
// while the pipeline was frozen. Clear beats load, load beats drain.
module fetch_hold_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [DATA_W-1:0] load_instr,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr
);

    // Entry register; clearing also zeroes the payload so nothing stale lingers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory req/ack handshake and IF/ID register.
// A branch redirects and flushes IF/ID; if the current request has not been
// acked yet it is drained (DRAIN) before the new target is requested.
// Optional macro FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [DATA_W-1:0] if_id_instr,
    output logic              if_id_valid
`ifdef FETCH_PERF_EN
   ,output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, drain_addr, pc_plus;
    logic              buf_v;
    logic [ADDR_W-1:0] buf_pc;
    logic [DATA_W-1:0] buf_instr;

    logic ifid_wr_fetch, ifid_wr_buf, ifid_clr;
    logic buf_load, buf_drain, buf_clear;
    logic pc_step, drain_set;

    assign pc_plus = pc + ADDR_W'(PC_STEP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // Next state; branch wins over freeze, acks in FULL are ignored
    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: begin
                if (branch_taken)            state_nxt = imem_ack ? FETCH : DRAIN;
                else if (imem_ack && freeze) state_nxt = FULL;
            end
            DRAIN: if (imem_ack)                 state_nxt = FETCH;
            FULL:  if (branch_taken || !freeze)  state_nxt = FETCH;
            default:                             state_nxt = FETCH;
        endcase
    end

    // Memory-side outputs and datapath strobes
    always_comb begin
        imem_req      = 1'b0;
        imem_addr     = pc;
        ifid_wr_fetch = 1'b0;
        ifid_wr_buf   = 1'b0;
        ifid_clr      = 1'b0;
        buf_load      = 1'b0;
        buf_drain     = 1'b0;
        buf_clear     = 1'b0;
        pc_step       = 1'b0;
        drain_set     = 1'b0;
        unique case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    ifid_clr  = 1'b1;
                    drain_set = !imem_ack;
                end else if (imem_ack) begin
                    pc_step = 1'b1;
                    if (freeze) buf_load      = 1'b1;
                    else        ifid_wr_fetch = 1'b1;
                end else if (!freeze) begin
                    ifid_clr = 1'b1;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                ifid_clr  = branch_taken || !freeze;
            end
            FULL: begin
                if (branch_taken) begin
                    buf_clear = 1'b1;
                    ifid_clr  = 1'b1;
                end else if (!freeze) begin
                    buf_drain   = 1'b1;
                    ifid_wr_buf = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // PC and the address of a request that must be drained after a redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            drain_addr <= '0;
        end else begin
            if (drain_set)         drain_addr <= pc;
            if (branch_taken)      pc <= branch_addr;
            else if (pc_step)      pc <= pc_plus;
        end
    end

    // IF/ID register: flush/bubble, direct write from memory, or buffer replay
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end else if (ifid_clr) begin
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end else if (ifid_wr_fetch) begin
            if_id_pc    <= pc_plus;
            if_id_instr <= imem_rdata;
            if_id_valid <= 1'b1;
        end else if (ifid_wr_buf) begin
            if_id_pc    <= buf_pc;
            if_id_instr <= buf_instr;
            if_id_valid <= buf_v;
        end
    end

    fetch_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .drain      (buf_drain),
        .clear      (buf_clear),
        .load_pc    (pc_plus),
        .load_instr (imem_rdata),
        .valid      (buf_v),
        .pc         (buf_pc),
        .instr      (buf_instr)
    );

`ifdef FETCH_PERF_EN
    // Count valid IF/ID writes and non-branch freeze cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (ifid_wr_fetch || ifid_wr_buf) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (freeze && !branch_taken)      perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios with literal expectations, then a long
// randomized run compared each cycle against a request-level model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid)
`ifdef FETCH_PERF_EN
       ,.perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: "parked" = a fetched instruction waiting for freeze to drop,
    // "stale" = a request in flight whose data is unwanted after a redirect.
    typedef struct {
        bit          parked, stale;
        logic [31:0] pc, stale_addr, park_pc, park_instr;
        logic [31:0] ifid_pc, ifid_instr;
        bit          ifid_v;
        logic [31:0] nfetch, nstall;
    } model_t;

    model_t m;

    function automatic model_t mreset();
        model_t r;
        r.parked = 0; r.stale = 0; r.pc = 32'h0; r.stale_addr = 0;
        r.park_pc = 0; r.park_instr = 0; r.ifid_pc = 0; r.ifid_instr = 0;
        r.ifid_v = 0; r.nfetch = 0; r.nstall = 0;
        return r;
    endfunction

    function automatic model_t mstep(model_t c, bit br, logic [31:0] ba, bit frz,
                                     bit ack, logic [31:0] rd);
        model_t n;
        n = c;
        if (frz && !br) n.nstall = c.nstall + 1;
        if (br) begin
            n.ifid_pc = 0; n.ifid_instr = 0; n.ifid_v = 0;
            n.pc = ba;
            if (c.parked) n.parked = 0;
            else if (c.stale) begin
                if (ack) n.stale = 0;
            end else if (!ack) begin
                n.stale = 1; n.stale_addr = c.pc;
            end
        end else if (c.parked) begin
            if (!frz) begin
                n.ifid_pc = c.park_pc; n.ifid_instr = c.park_instr; n.ifid_v = 1;
                n.parked = 0; n.nfetch = c.nfetch + 1;
            end
        end else if (c.stale) begin
            if (ack) n.stale = 0;
            if (!frz) begin n.ifid_pc = 0; n.ifid_instr = 0; n.ifid_v = 0; end
        end else if (ack) begin
            n.pc = c.pc + 32'd4;
            if (frz) begin
                n.parked = 1; n.park_pc = c.pc + 32'd4; n.park_instr = rd;
            end else begin
                n.ifid_pc = c.pc + 32'd4; n.ifid_instr = rd; n.ifid_v = 1;
                n.nfetch = c.nfetch + 1;
            end
        end else if (!frz) begin
            n.ifid_pc = 0; n.ifid_instr = 0; n.ifid_v = 0;
        end
        return n;
    endfunction

    function automatic bit m_req();
        return !m.parked;
    endfunction

    function automatic logic [31:0] m_addr();
        return m.stale ? m.stale_addr : m.pc;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= mreset();
        else     m <= mstep(m, branch_taken, branch_addr, freeze, imem_ack, imem_rdata);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req", {31'b0, imem_req}, {31'b0, m_req()});
            if (m_req()) chk("addr", imem_addr, m_addr());
            chk("ifid_valid", {31'b0, if_id_valid}, {31'b0, m.ifid_v});
            chk("ifid_pc", if_id_pc, m.ifid_pc);
            chk("ifid_instr", if_id_instr, m.ifid_instr);
`ifdef FETCH_PERF_EN
            chk("perf_fetch", perf_fetch_cnt, m.nfetch);
            chk("perf_stall", perf_stall_cnt, m.nstall);
`endif
        end
    end

    task automatic drive(input bit frz, input bit br, input logic [31:0] ba,
                         input bit ack, input logic [31:0] rd);
        freeze = frz; branch_taken = br; branch_addr = ba;
        imem_ack = ack; imem_rdata = rd;
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_req"}, {31'b0, imem_req}, 32'd1);
        chk({nm, "_addr"}, imem_addr, 32'h0);
        chk({nm, "_pc"}, if_id_pc, 32'h0);
        chk({nm, "_instr"}, if_id_instr, 32'h0);
        chk({nm, "_valid"}, {31'b0, if_id_valid}, 32'd0);
    endtask

    initial begin
        bit frz, br, ack;
        logic [31:0] ba;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        cmp_en = 1'b1;

        // zero-wait streaming, data = address
        chk("s_addr0", imem_addr, 32'h0);
        drive(0, 0, 0, 1, 32'h0);
        chk("s_pc4", if_id_pc, 32'h4);  chk("s_v4", {31'b0, if_id_valid}, 32'd1);
        chk("s_addr4", imem_addr, 32'h4);
        drive(0, 0, 0, 1, 32'h4);
        chk("s_pc8", if_id_pc, 32'h8);  chk("s_i8", if_id_instr, 32'h4);
        chk("s_addr8", imem_addr, 32'h8);
        drive(0, 0, 0, 1, 32'h8);
        chk("s_pc12", if_id_pc, 32'hC);
        drive(0, 0, 0, 1, 32'hC);
        chk("s_addr16", imem_addr, 32'h10);

        // freeze while the ack at 0x10 returns
        drive(1, 0, 0, 1, 32'h10);
        chk("f_req0", {31'b0, imem_req}, 32'd0);
        chk("f_hold_pc", if_id_pc, 32'h10);
        drive(1, 0, 0, 1, 32'hDEAD);      // ack without request: ignored
        chk("f_hold_pc2", if_id_pc, 32'h10);
        drive(1, 0, 0, 0, 32'h0);
        chk("f_hold_instr", if_id_instr, 32'hC);
        drive(0, 0, 0, 0, 32'h0);
        chk("f_rel_pc", if_id_pc, 32'h14);
        chk("f_rel_instr", if_id_instr, 32'h10);
        chk("f_rel_addr", imem_addr, 32'h14);
        chk("f_rel_req", {31'b0, imem_req}, 32'd1);
`ifdef FETCH_PERF_EN
        chk("perf_fetch_lit", perf_fetch_cnt, 32'd5);
        chk("perf_stall_lit", perf_stall_cnt, 32'd3);
`endif

        // branch with outstanding request
        drive(0, 1, 32'h100, 0, 32'h0);
        chk("b_addr_old", imem_addr, 32'h14);
        chk("b_v0", {31'b0, if_id_valid}, 32'd0);
        drive(0, 0, 0, 0, 32'h0);
        chk("b_addr_old2", imem_addr, 32'h14);
        drive(0, 0, 0, 1, 32'hBAD);
        chk("b_addr_new", imem_addr, 32'h100);
        chk("b_v1", {31'b0, if_id_valid}, 32'd0);
        chk("b_instr", if_id_instr, 32'h0);

        // branch plus freeze in FULL
        drive(1, 0, 0, 1, 32'h100);
        chk("bf_full", {31'b0, imem_req}, 32'd0);
        drive(1, 1, 32'h200, 0, 32'h0);
        chk("bf_addr", imem_addr, 32'h200);
        chk("bf_pc", if_id_pc, 32'h0);
        chk("bf_v", {31'b0, if_id_valid}, 32'd0);
        drive(0, 0, 0, 1, 32'h200);
        chk("bf_next_pc", if_id_pc, 32'h204);
        chk("bf_next_instr", if_id_instr, 32'h200);

        // PC wrap
        drive(0, 1, 32'hFFFF_FFFC, 1, 32'h1234);
        chk("w_addr", imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        chk("w_addr0", imem_addr, 32'h0);
        chk("w_pc0", if_id_pc, 32'h0);
        chk("w_v", {31'b0, if_id_valid}, 32'd1);

        // randomized run with occasional asynchronous reset mid-cycle
        for (int i = 0; i < 4000; i++) begin
            frz = ($urandom_range(0, 99) < 25);
            br  = ($urandom_range(0, 99) < 8);
            ba  = $urandom_range(0, 1) ? {$urandom_range(0, 32'h3FFF), 2'b00} : $urandom;
            ack = m_req() ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 15);
            freeze = frz; branch_taken = br; branch_addr = ba;
            imem_ack = ack; imem_rdata = $urandom;
            if (i % 700 == 350) begin
                #2 rst = 1'b1;
                #1 chk_reset_vals("async_rst");
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
